// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between an audio source (master) and the I2S transmitter (slave).
interface i2s_tx_if;
    logic [23:0] l;
    logic [23:0] r;
    logic        valid;
    logic        ready;

    modport master (output l, output r, output valid, input ready);
    modport slave  (input l, input r, input valid, output ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: 64-BCLK frames, 24-bit MSB-first samples, one-entry holding buffer.
// Optional o_underflow_cnt output is enabled by defining I2S_TX_UNDERFLOW_CNT_EN.
module i2s_tx #(
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic    i_clk48,
    input  logic    i_rst,
    i2s_tx_if.slave s_in,
    output logic    o_bclk,
    output logic    o_lrclk,
    output logic    o_sdata,
    output logic    o_frame_start
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] o_underflow_cnt
`endif
);
    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = 6;
    localparam int unsigned SMP_W = 24;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_bclk;
    logic [BIT_W-1:0] r_bit;
    logic             r_lrclk;
    logic             r_sdata;
    logic             r_frame_start;
    logic             r_full;
    logic             r_ready;
    logic [SMP_W-1:0] r_hold_l;
    logic [SMP_W-1:0] r_hold_r;
    logic [SMP_W-1:0] r_sh_l;
    logic [SMP_W-1:0] r_sh_r;

    logic             w_tc;
    logic             w_fall;
    logic             w_load;
    logic             w_accept;
    logic             w_full_next;
    logic             w_left_slot;
    logic             w_right_slot;
    logic [BIT_W-1:0] w_bit_next;

    // Falling BCLK edges advance the bit index; the 63->0 wrap is the frame load.
    always_comb begin
        w_tc         = (r_div == DIV_TC);
        w_fall       = w_tc && r_bclk;
        w_bit_next   = r_bit + BIT_W'(1);
        w_load       = w_fall && (r_bit == BIT_W'(63));
        w_accept     = s_in.valid && r_ready;
        w_full_next  = w_load ? w_accept : (r_full || w_accept);
        w_left_slot  = (w_bit_next >= BIT_W'(1))  && (w_bit_next <= BIT_W'(24));
        w_right_slot = (w_bit_next >= BIT_W'(33)) && (w_bit_next <= BIT_W'(56));
    end

    always_ff @(posedge i_clk48) begin
        if (i_rst) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_tc) begin
            r_div  <= '0;
            r_bclk <= !r_bclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    // Serializer: LRCLK/SDATA update on falling BCLK, MSB one bit after the LRCLK edge.
    always_ff @(posedge i_clk48) begin
        if (i_rst) begin
            r_bit         <= '0;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_sh_l        <= '0;
            r_sh_r        <= '0;
        end else begin
            r_frame_start <= w_load;
            if (w_fall) begin
                r_bit   <= w_bit_next;
                r_lrclk <= w_bit_next[BIT_W-1];
                r_sdata <= 1'b0;
                if (w_left_slot) begin
                    r_sdata <= r_sh_l[SMP_W-1];
                    r_sh_l  <= {r_sh_l[SMP_W-2:0], 1'b0};
                end
                if (w_right_slot) begin
                    r_sdata <= r_sh_r[SMP_W-1];
                    r_sh_r  <= {r_sh_r[SMP_W-2:0], 1'b0};
                end
            end
            // An empty buffer at load time yields a silent frame.
            if (w_load) begin
                r_sh_l <= r_full ? r_hold_l : '0;
                r_sh_r <= r_full ? r_hold_r : '0;
            end
        end
    end

    always_ff @(posedge i_clk48) begin
        if (i_rst) begin
            r_full   <= 1'b0;
            r_ready  <= 1'b0;
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else begin
            r_full  <= w_full_next;
            r_ready <= !w_full_next;
            if (w_accept) begin
                r_hold_l <= s_in.l;
                r_hold_r <= s_in.r;
            end
        end
    end

    assign s_in.ready    = r_ready;
    assign o_bclk        = r_bclk;
    assign o_lrclk       = r_lrclk;
    assign o_sdata       = r_sdata;
    assign o_frame_start = r_frame_start;

`ifdef I2S_TX_UNDERFLOW_CNT_EN
    logic [15:0] r_underflow_cnt;

    always_ff @(posedge i_clk48) begin
        if (i_rst) begin
            r_underflow_cnt <= '0;
        end else if (w_load && !r_full && (r_underflow_cnt != 16'hFFFF)) begin
            r_underflow_cnt <= r_underflow_cnt + 16'd1;
        end
    end

    assign o_underflow_cnt = r_underflow_cnt;
`endif
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: arithmetic timing model plus a transaction-level buffer model.
module tb_i2s_tx;
    localparam int unsigned D0  = 8;
    localparam int unsigned D1  = 1;
    localparam int unsigned FR0 = 128 * D0;
    localparam int unsigned FR1 = 128 * D1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_tx_if u_if0 ();
    i2s_tx_if u_if1 ();

    logic bclk0, lrclk0, sdata0, fs0;
    logic bclk1, lrclk1, sdata1, fs1;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    logic [15:0] ucnt0, ucnt1;
`endif

    i2s_tx #(.BCLK_DIV(D0)) u_dut0 (
        .i_clk48(clk), .i_rst(rst), .s_in(u_if0),
        .o_bclk(bclk0), .o_lrclk(lrclk0), .o_sdata(sdata0), .o_frame_start(fs0)
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        , .o_underflow_cnt(ucnt0)
`endif
    );

    i2s_tx #(.BCLK_DIV(D1)) u_dut1 (
        .i_clk48(clk), .i_rst(rst), .s_in(u_if1),
        .o_bclk(bclk1), .o_lrclk(lrclk1), .o_sdata(sdata1), .o_frame_start(fs1)
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        , .o_underflow_cnt(ucnt1)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state for u_dut0: k = clock edges since reset release.
    int unsigned k = 0;
    logic        m_full = 1'b0;
    logic        m_ready = 1'b0;
    logic [23:0] m_hold_l = '0, m_hold_r = '0;
    logic [23:0] m_cur_l = '0, m_cur_r = '0;
    logic [15:0] m_ucnt = '0;
    int          dut_acc = 0;

    // Expected {bclk, lrclk, sdata, frame_start, ready} from elapsed cycles and frame contents.
    function automatic logic [4:0] exp_vec(input int unsigned kk, input int unsigned d,
                                           input logic [23:0] cl, input logic [23:0] cr,
                                           input logic rdy);
        int unsigned b;
        logic sd;
        b  = (kk / (2 * d)) % 64;
        sd = 1'b0;
        if (b >= 1 && b <= 24)       sd = cl[24 - b];
        else if (b >= 33 && b <= 56) sd = cr[56 - b];
        return {((kk / d) % 2) == 1, b >= 32, sd, (kk != 0) && (kk % (128 * d) == 0), rdy};
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then settle.
    task automatic cyc();
        logic r_in, acc;
        logic [23:0] il, ir;
        r_in = rst;
        acc  = u_if0.valid && m_ready && !rst;
        il   = u_if0.l;
        ir   = u_if0.r;
        if (u_if0.valid && u_if0.ready && !rst) dut_acc++;
        @(posedge clk);
        if (r_in) begin
            k = 0; m_full = 1'b0; m_ready = 1'b0;
            m_cur_l = '0; m_cur_r = '0; m_ucnt = '0;
        end else begin
            k++;
            if (k % FR0 == 0) begin
                if (m_full) begin
                    m_cur_l = m_hold_l; m_cur_r = m_hold_r;
                end else begin
                    m_cur_l = '0; m_cur_r = '0;
                    if (m_ucnt != 16'hFFFF) m_ucnt++;
                end
                m_full = 1'b0;
            end
            if (acc) begin
                m_full = 1'b1; m_hold_l = il; m_hold_r = ir;
            end
            m_ready = !m_full;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        u_if0.valid = 1'b0;
        u_if1.valid = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        dut_acc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if0.valid = 1'b1;
        u_if0.l = 24'($urandom);
        u_if0.r = 24'($urandom);
        repeat (4) begin
            cyc();
            checks++;
            if ({bclk0, lrclk0, sdata0, fs0, u_if0.ready} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs got %b exp %b", {bclk0, lrclk0, sdata0, fs0, u_if0.ready}, 5'b0);
            end
        end
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        checks++;
        if (ucnt0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_ucnt got %0d exp 0", ucnt0);
        end
`endif
        u_if0.valid = 1'b0;
        rst = 1'b0;
        cyc();
        checks++;
        if (u_if0.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", u_if0.ready);
        end
    endtask

    task automatic test_idle();
        do_reset();
        repeat (3 * FR0 + 20) begin
            cyc();
            checks++;
            if ({bclk0, lrclk0, sdata0, fs0, u_if0.ready} !== exp_vec(k, D0, m_cur_l, m_cur_r, m_ready)) begin
                errors++;
                $display("FAIL idle k=%0d got %b exp %b", k, {bclk0, lrclk0, sdata0, fs0, u_if0.ready},
                         exp_vec(k, D0, m_cur_l, m_cur_r, m_ready));
            end
        end
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        checks++;
        if (ucnt0 !== 16'd3) begin
            errors++;
            $display("FAIL idle_ucnt got %0d exp 3", ucnt0);
        end
`endif
    endtask

    task automatic test_single();
        int unsigned wait_c;
        do_reset();
        wait_c = $urandom_range(900, 5);
        while (k < 3 * FR0 + 16) begin
            u_if0.valid = (k == wait_c);
            u_if0.l = (k == wait_c) ? 24'hA5A5A5 : 24'($urandom);
            u_if0.r = (k == wait_c) ? 24'h5A5A5A : 24'($urandom);
            cyc();
            checks++;
            if ({bclk0, lrclk0, sdata0, fs0, u_if0.ready} !== exp_vec(k, D0, m_cur_l, m_cur_r, m_ready)) begin
                errors++;
                $display("FAIL single k=%0d got %b exp %b", k, {bclk0, lrclk0, sdata0, fs0, u_if0.ready},
                         exp_vec(k, D0, m_cur_l, m_cur_r, m_ready));
            end
        end
        u_if0.valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [23:0] base;
        int idx, seen;
        do_reset();
        base = 24'($urandom);
        idx  = 0;
        u_if0.valid = 1'b1;
        u_if0.l = base;
        u_if0.r = ~base;
        repeat (5 * FR0 + 50) begin
            seen = dut_acc;
            cyc();
            if (m_full && m_hold_l == u_if0.l && seen != dut_acc) begin
                idx++;
                u_if0.l = base + 24'(idx);
                u_if0.r = ~(base + 24'(idx));
            end
            checks++;
            if ({bclk0, lrclk0, sdata0, fs0, u_if0.ready} !== exp_vec(k, D0, m_cur_l, m_cur_r, m_ready)) begin
                errors++;
                $display("FAIL stream k=%0d got %b exp %b", k, {bclk0, lrclk0, sdata0, fs0, u_if0.ready},
                         exp_vec(k, D0, m_cur_l, m_cur_r, m_ready));
            end
        end
        u_if0.valid = 1'b0;
        checks++;
        if (dut_acc !== 6) begin
            errors++;
            $display("FAIL stream_accepts got %0d exp 6", dut_acc);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        while (k < 4 * FR0 - 16) begin
            // First pulse lands on the load edge, second on the FRAME_START cycle.
            u_if0.valid = (k == FR0 - 1) || (k == 2 * FR0);
            u_if0.l = 24'($urandom);
            u_if0.r = 24'($urandom);
            cyc();
            checks++;
            if ({bclk0, lrclk0, sdata0, fs0, u_if0.ready} !== exp_vec(k, D0, m_cur_l, m_cur_r, m_ready)) begin
                errors++;
                $display("FAIL same_cycle k=%0d got %b exp %b", k, {bclk0, lrclk0, sdata0, fs0, u_if0.ready},
                         exp_vec(k, D0, m_cur_l, m_cur_r, m_ready));
            end
        end
        u_if0.valid = 1'b0;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        checks++;
        if (ucnt0 !== 16'd1) begin
            errors++;
            $display("FAIL same_cycle_ucnt got %0d exp 1", ucnt0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int unsigned stop_k;
        do_reset();
        stop_k = FR0 + 40 * 2 * D0 + 3;
        while (k < stop_k) begin
            u_if0.valid = (k == 100) || (k == FR0 + 50);
            u_if0.l = 24'($urandom);
            u_if0.r = 24'($urandom);
            cyc();
            checks++;
            if ({bclk0, lrclk0, sdata0, fs0, u_if0.ready} !== exp_vec(k, D0, m_cur_l, m_cur_r, m_ready)) begin
                errors++;
                $display("FAIL reset_mid_pre k=%0d got %b exp %b", k, {bclk0, lrclk0, sdata0, fs0, u_if0.ready},
                         exp_vec(k, D0, m_cur_l, m_cur_r, m_ready));
            end
        end
        u_if0.valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({bclk0, lrclk0, sdata0, fs0, u_if0.ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_abort got %b exp %b", {bclk0, lrclk0, sdata0, fs0, u_if0.ready}, 5'b0);
        end
        repeat (2 * FR0 + 20) begin
            cyc();
            checks++;
            if ({bclk0, lrclk0, sdata0, fs0, u_if0.ready} !== exp_vec(k, D0, 24'd0, 24'd0, 1'b1)) begin
                errors++;
                $display("FAIL reset_mid_silent k=%0d got %b exp %b", k, {bclk0, lrclk0, sdata0, fs0, u_if0.ready},
                         exp_vec(k, D0, 24'd0, 24'd0, 1'b1));
            end
        end
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        checks++;
        if (ucnt0 !== 16'd2) begin
            errors++;
            $display("FAIL reset_mid_ucnt got %0d exp 2", ucnt0);
        end
`endif
    endtask

    task automatic test_div1();
        logic [23:0] pl, pr, cl, cr;
        logic rdy;
        do_reset();
        pl = 24'($urandom);
        pr = 24'($urandom);
        u_if1.l = pl;
        u_if1.r = pr;
        while (k < 3 * FR1 + 10) begin
            u_if1.valid = (k < 2);
            cyc();
            cl  = (k / FR1 == 1) ? pl : 24'd0;
            cr  = (k / FR1 == 1) ? pr : 24'd0;
            rdy = (k == 1) || (k >= FR1);
            checks++;
            if ({bclk1, lrclk1, sdata1, fs1, u_if1.ready} !== exp_vec(k, D1, cl, cr, rdy)) begin
                errors++;
                $display("FAIL div1 k=%0d got %b exp %b", k, {bclk1, lrclk1, sdata1, fs1, u_if1.ready},
                         exp_vec(k, D1, cl, cr, rdy));
            end
        end
        u_if1.valid = 1'b0;
    endtask

    initial begin
        u_if0.valid = 1'b0; u_if0.l = '0; u_if0.r = '0;
        u_if1.valid = 1'b0; u_if1.l = '0; u_if1.r = '0;
        test_reset();
        test_idle();
        test_single();
        test_stream();
        test_same_cycle();
        test_reset_mid();
        test_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter BCLK_DIV, default 8: CLK48 cycles per BCLK half-period; legal range 1..255.
REQ-002 CLK48  input  1  audio clock (48 MHz); sole clock; all logic on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 IN_L  input  24  left sample, two's complement.
REQ-005 IN_R  input  24  right sample, two's complement.
REQ-006 IN_VALID  input  1  sample pair offered.
REQ-007 IN_READY  output  1  holding buffer empty; pair accepted when IN_VALID&&IN_READY.
REQ-008 BCLK  output  1  serial bit clock to codec.
REQ-009 LRCLK  output  1  word select; 0 = left, 1 = right.
REQ-010 SDATA  output  1  serial data, I2S format.
REQ-011 FRAME_START  output  1  one-cycle pulse on each frame load.

Function
REQ-012 Divider counter 0..BCLK_DIV-1; at terminal count BCLK toggles and counter returns to 0.
REQ-013 Bit index b (0..63) advances only on cycles where BCLK toggles 1->0; 63 wraps to 0.
REQ-014 Frame = 64 BCLK periods = 128*BCLK_DIV CLK48 cycles (1024 at default; fs = 46.875 kHz).
REQ-015 LRCLK = 0 for b 0..31, 1 for b 32..63; LRCLK and SDATA change only on BCLK falling edge.
REQ-016 SDATA = left bit 23-(b-1) for b 1..24, right bit 23-(b-33) for b 33..56, else 0; MSB one BCLK after LRCLK edge.
REQ-017 Holding buffer, one entry: accept sets full, IN_READY = !full, registered; no combinational path IN_VALID->IN_READY.
REQ-018 Frame load occurs on the cycle b wraps 63->0: buffer full -> copy to shift registers, buffer empties, FRAME_START = 1.
REQ-019 Frame load with buffer empty (underflow) -> shift registers loaded with zero, FRAME_START = 1, frame transmits silence.
REQ-020 Accept and frame load in same cycle with buffer empty: loaded frame is zero; accepted pair held for next frame.
REQ-021 Buffer never overwritten; held data stable until loaded.
REQ-022 IN_L/IN_R sampled only at accept; changes while IN_READY = 0 have no effect.

Reset
REQ-023 While RST = 1: BCLK 0, LRCLK 0, SDATA 0, FRAME_START 0, IN_READY 0, divider 0, b 0, buffer empty, shift registers 0.
REQ-024 First cycle after RST deasserts: IN_READY 1; first frame (b = 0..63) transmits zeros and does not count as underflow.
REQ-025 RST asserted mid-frame aborts the frame immediately and discards buffered data; outputs at reset values next cycle.

Configuration
REQ-026 Macro I2S_TX_UNDERFLOW_CNT_EN defined: output UNDERFLOW_CNT [15:0] added, +1 on each REQ-019 load (excluding REQ-024 frame), saturates at 16'hFFFF, cleared by RST.
REQ-027 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-028 Reset release, no input -> BCLK period 16 cycles, LRCLK period 1024 cycles, SDATA constant 0, FRAME_START every 1024 cycles.
REQ-029 IN_L = 24'hA5A5A5, IN_R = 24'h5A5A5A, one valid pulse -> next frame: b 1..24 serialize A5A5A5 MSB first, b 33..56 serialize 5A5A5A, rest 0; IN_READY reasserts on that FRAME_START.
REQ-030 IN_VALID held 1 with incrementing pairs -> exactly one pair consumed per frame, none skipped or repeated; IN_READY low between accept and next load.
REQ-031 Valid pulse on same cycle as FRAME_START with buffer empty -> that frame zero, following frame carries the pair; with UNDERFLOW_CNT_EN, counter = 1.
REQ-032 RST pulsed at b = 40 with buffer full -> outputs reset next cycle, buffered pair never transmitted, following frame silent.
REQ-033 BCLK_DIV = 1 -> BCLK = CLK48/2, frame = 128 cycles, data alignment as REQ-016.
